// File: rtl/debounce_multi_if.sv
// Front-panel debouncer bus: raw inputs in, filtered levels and strobes out.
// master drives the raw pins, slave is the debouncer.
interface debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] rpt_pulse;
    logic                any_press;

    modport master (
        output in,
        input  level,
        input  press_pulse,
        input  release_pulse,
        input  rpt_pulse,
        input  any_press
    );

    modport slave (
        input  in,
        output level,
        output press_pulse,
        output release_pulse,
        output rpt_pulse,
        output any_press
    );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel button/switch debouncer with press/release strobes
// and optional auto-repeat while a button is held.
module debounce_multi #(
    parameter int CHANNELS        = 4,
    parameter int CNT_W           = 24,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic             clk,
    input  logic             reset,
    debounce_multi_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_LO,
        CHK_HI,
        ST_HI,
        CHK_LO
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CHANNELS-1:0] s1_q, s2_q;
    logic [CHANNELS-1:0] level_d, press_d, rel_d, rpt_d;
    logic [CHANNELS-1:0] level_q, press_q, rel_q, rpt_q;
    logic                any_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            rpt_q   <= '0;
            any_q   <= 1'b0;
        end else begin
            s1_q    <= bus.in;
            s2_q    <= s1_q;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rpt_q   <= rpt_d;
            any_q   <= |press_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] rcnt_q, rcnt_d;
        logic             ph_q, ph_d;
        logic             press_c, rel_c, rpt_c;
        logic             s;

        assign s = s2_q[i];

        always_comb begin
            st_d    = st_q;
            cnt_d   = cnt_q;
            rcnt_d  = rcnt_q;
            ph_d    = ph_q;
            press_c = 1'b0;
            rel_c   = 1'b0;
            rpt_c   = 1'b0;
            unique case (st_q)
                ST_LO: begin
                    if (s) begin
                        st_d  = CHK_HI;
                        cnt_d = ONE;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        st_d  = ST_LO;
                        cnt_d = '0;
                    end else if (cnt_q == DB_LAST) begin
                        st_d    = ST_HI;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                        press_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        st_d  = CHK_LO;
                        cnt_d = ONE;
                    end else if (REPEAT_EN != 0) begin
                        // First strobe waits the long delay, later ones the period
                        if ((!ph_q && rcnt_q == RD_LAST) ||
                            (ph_q && rcnt_q == RP_LAST)) begin
                            rpt_c  = 1'b1;
                            ph_d   = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + ONE;
                        end
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        st_d  = ST_HI;
                        cnt_d = '0;
                    end else if (cnt_q == DB_LAST) begin
                        st_d  = ST_LO;
                        cnt_d = '0;
                        ph_d  = 1'b0;
                        rel_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: st_d = ST_LO;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                st_q   <= ST_LO;
                cnt_q  <= '0;
                rcnt_q <= '0;
                ph_q   <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                rcnt_q <= rcnt_d;
                ph_q   <= ph_d;
            end
        end

        assign level_d[i] = (st_d == ST_HI) || (st_d == CHK_LO);
        assign press_d[i] = press_c;
        assign rel_d[i]   = rel_c;
        assign rpt_d[i]   = rpt_c;
    end

    assign bus.level         = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.rpt_pulse     = rpt_q;
    assign bus.any_press     = any_q;
endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Multi-channel, parametrised debouncer for the vending machine's front-panel buttons and coin-slot switches. Each channel synchronises a raw asynchronous input, filters bounce with a per-channel stability counter, and produces three outputs: a debounced level, one-cycle press and release strobes, and an optional auto-repeat strobe while the input is held. It sits between the board pins and the vending FSM. All channels are fully independent.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
CNT_W, 24, width of the per-channel stability and repeat counters
DEBOUNCE_CYCLES, 12000, consecutive stable synchronised samples required to accept a new level (2 .. 2^CNT_W-1)
REPEAT_EN, 0, 1 enables auto-repeat strobes while held; 0 ties rpt_pulse to 0
REPEAT_DELAY, 6000000, cycles in STABLE_HI before the first rpt_pulse (>=1, < 2^CNT_W)
REPEAT_PERIOD, 1200000, cycles between subsequent rpt_pulse strobes (>=1, < 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in  input  CHANNELS  raw asynchronous button/switch inputs, active-high
level  output  CHANNELS  debounced level per channel
press_pulse  output  CHANNELS  1-cycle strobe on an accepted 0->1 transition
release_pulse  output  CHANNELS  1-cycle strobe on an accepted 1->0 transition
rpt_pulse  output  CHANNELS  1-cycle auto-repeat strobe while held
any_press  output  1  OR-reduction of press_pulse, registered together with it

Behaviour:
- Reset: synchronous, active-high on clk. Clears all sync flops, counters and outputs to 0 and puts every channel in STABLE_LO. Reset has priority over all other activity, including reset asserted mid-count or mid-hold. No release_pulse is generated by reset.
- Synchroniser: two-flop chain per channel. s[i] is the second stage, so there are 2 cycles of latency from in to s.
- Per-channel FSM, evaluated on s[i]:
  - STABLE_LO: level=0. If s=1, go to CHK_HI with cnt=1.
  - CHK_HI: if s=0, go to STABLE_LO with cnt=0 (bounce rejected, no strobe). If s=1 and cnt==DEBOUNCE_CYCLES-1, go to STABLE_HI, set level=1, set press_pulse=1 for 1 cycle, clear rcnt. Otherwise cnt++.
  - STABLE_HI: level=1. If s=0, go to CHK_LO with cnt=1 and freeze rcnt. Otherwise run the repeat logic.
  - CHK_LO: if s=1, return to STABLE_HI with cnt=0; rcnt resumes from its frozen value and no strobe is generated. If s=0 and cnt==DEBOUNCE_CYCLES-1, go to STABLE_LO, set level=0, set release_pulse=1 for 1 cycle. Otherwise cnt++.
- Latency: from a clean input edge to the level change and its strobe is exactly 2+DEBOUNCE_CYCLES rising edges. The strobe is asserted in the same cycle that level changes.
- Repeat (REPEAT_EN=1, STABLE_HI only):
  - rcnt increments each cycle.
  - At the first entry, rcnt==REPEAT_DELAY-1 raises rpt_pulse for 1 cycle and sets the rep_phase flag. rcnt then clears.
  - Afterwards, rcnt==REPEAT_PERIOD-1 raises rpt_pulse for 1 cycle and rcnt clears.
  - rep_phase clears on entry to STABLE_LO.
  - press_pulse and rpt_pulse are never high in the same cycle.
- Strobes are registered. Every strobe is exactly 1 cycle wide, with no back-to-back duplicates from a single transition.
- Simultaneous events on different channels are handled independently. Multiple bits of press_pulse may be set in one cycle; any_press is 1 in exactly those cycles.
- Counters never wrap: parameter ranges guarantee that the compare value is reached before overflow.
- in held high through reset release: this produces a normal press after 2+DEBOUNCE_CYCLES cycles.

Test Plan:
- DEBOUNCE_CYCLES=4, in[0] 0->1 and held. Required: level[0] and press_pulse[0] rise after the 6th rising edge; press_pulse[0] falls after 1 cycle; no release_pulse.
- DEBOUNCE_CYCLES=4, in[1] pulses high for 3 cycles, low for 1, high for 3, then low. Required: level[1], press_pulse[1] and any_press stay 0 throughout.
- Channel held high, then in goes low for DEBOUNCE_CYCLES+2 cycles. Required: level drops after 2+DEBOUNCE_CYCLES edges; release_pulse is high for exactly 1 cycle; a 2-cycle low glitch while held produces nothing.
- REPEAT_EN=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, hold 40 cycles. Required: press_pulse at cycle 6, rpt_pulse at 16, 21, 26, 31, 36, 41 (relative to in rising).
- in[0] and in[3] rise on the same edge. Required: press_pulse=4'b1001 and any_press=1 in the same single cycle.
- Reset asserted while CHK_HI cnt=2 and while STABLE_HI. Required: all outputs 0 on the next edge; no release_pulse; after reset deasserts with in still high, press_pulse fires 2+DEBOUNCE_CYCLES cycles later.
